// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipeline's memory-access stage.
// Captures one load/store request, waits LATENCY cycles while holding the
// pipeline stall, performs the access against an internal word RAM and
// returns a one-cycle response carrying the extended load data.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   -> misaligned halfword/word accesses are rejected with misalign_err
//   undefined -> misaligned accesses are forced to natural alignment, misalign_err=0
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misalign_err
);

    localparam int AW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nx_s;
    logic              do_access_s;

    logic              wen_r;
    logic [1:0]        size_r;
    logic              sign_r;
    logic [AW-1:0]     addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              misalign_r;

    logic [31:0]           mem_r [0:(2**ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [31:0]           rd_word_s;
    logic                  misalign_s;
    logic                  unused_addr_s;

    // Select the addressed lane, right-justify it and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sign & b[7]}}, b};
            2'b01:   r = {{16{sign & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Merge store data into the old word, touching only the addressed lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [3:0]  mask;
        logic [31:0] wr;
        logic [31:0] res;
        case (size)
            2'b00: begin
                mask = 4'b0001 << lane;
                wr   = {4{wdata[7:0]}};
            end
            2'b01: begin
                mask = lane[1] ? 4'b1100 : 4'b0011;
                wr   = {2{wdata[15:0]}};
            end
            default: begin
                mask = 4'b1111;
                wr   = wdata;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? wr[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    // Address bits above the RAM span are ignored, so accesses wrap.
    assign unused_addr_s = ^req_addr[31:AW];

    assign word_idx_s = addr_r[AW-1:2];
    assign rd_word_s  = mem_r[word_idx_s];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_s = ((size_r == 2'b01) && addr_r[0]) ||
                        (size_r[1] && (addr_r[1:0] != 2'b00));
`else
    // Halfword lane uses only addr[1] and word ignores addr[1:0], so
    // misaligned accesses naturally fall onto the aligned location.
    assign misalign_s = 1'b0;
`endif

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic: capture, count down wait states, respond for one cycle.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        do_access_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nx_s = WAIT;
                    cnt_nx_s   = 4'(LATENCY - 1);
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r != 4'd0) begin
                    cnt_nx_s = cnt_r - 4'd1;
                end else begin
                    do_access_s = 1'b1;
                    state_nx_s  = RESP;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // Request capture and registered response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_r      <= 1'b0;
            size_r     <= 2'b00;
            sign_r     <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            rdata_r    <= 32'd0;
            misalign_r <= 1'b0;
        end else begin
            if ((state_r == IDLE) && req_valid) begin
                wen_r   <= req_wen;
                size_r  <= req_size;
                sign_r  <= req_sign;
                addr_r  <= req_addr[AW-1:0];
                wdata_r <= req_wdata;
            end
            if (do_access_s) begin
                rdata_r    <= (wen_r || misalign_s) ? 32'd0 :
                              load_extract(rd_word_s, size_r, addr_r[1:0], sign_r);
                misalign_r <= misalign_s;
            end
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_access_s && wen_r && !misalign_s && !rst) begin
            mem_r[word_idx_s] <= store_merge(rd_word_s, wdata_r, size_r, addr_r[1:0]);
        end
    end

    // Stall covers the first request cycle combinationally, then all of WAIT.
    assign stall        = !rst && (((state_r == IDLE) && req_valid) || (state_r == WAIT));
    assign resp_valid   = (state_r == RESP);
    assign rdata        = rdata_r;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: scoreboard of expected responses checked by a
// response monitor, plus per-scenario latency/stall checks.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_rd_q [$];
    logic        exp_err_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_sign     (req_sign),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .rdata        (rdata),
        .misalign_err (misalign_err)
    );

    // Response monitor: pop the scoreboard on every response pulse.
    always @(negedge clk) begin
        logic [31:0] er;
        logic        ee;
        if (!rst && resp_valid) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp rdata=%h err=%b", rdata, misalign_err);
            end else begin
                er = exp_rd_q.pop_front();
                ee = exp_err_q.pop_front();
                checks++;
                if (rdata !== er) begin
                    failures++;
                    $display("FAIL resp_rdata got=%h exp=%h", rdata, er);
                end
                checks++;
                if (misalign_err !== ee) begin
                    failures++;
                    $display("FAIL resp_misalign got=%b exp=%b", misalign_err, ee);
                end
            end
        end
    end

    // Drive one request, hold it until the response, check latency and stall window.
    task automatic issue_req(input logic wen, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input logic exp_err,
                             input string name);
        int k;
        int nst;
        bit got;
        exp_rd_q.push_back(exp_rd);
        exp_err_q.push_back(exp_err);
        @(posedge clk);
        #1;
        req_wen   = wen;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        k = 0;
        nst = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            if (stall) nst++;
            if (resp_valid) begin
                got = 1'b1;
                req_valid = 1'b0;
                checks++;
                if (k !== LAT + 1) begin
                    failures++;
                    $display("FAIL %s latency got=%0d exp=%0d", name, k, LAT + 1);
                end
                checks++;
                if (nst !== LAT + 1) begin
                    failures++;
                    $display("FAIL %s stall_cycles got=%0d exp=%0d", name, nst, LAT + 1);
                end
            end
            k++;
        end
        if (!got) begin
            checks++;
            failures++;
            req_valid = 1'b0;
            $display("FAIL %s timeout got=no_resp exp=resp", name);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_size  = 2'b10;
        req_sign  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (stall !== 1'b0)        begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (resp_valid !== 1'b0)   begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (rdata !== 32'd0)       begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", stall); end
    endtask

    task automatic test_basic();
        issue_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 32'd0,        1'b0, "store_word");
        issue_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0,        32'hDEADBEEF, 1'b0, "load_word");
    endtask

    task automatic test_byte_lanes();
        issue_req(1'b1, 2'b00, 1'b0, 32'h41, 32'hFFFFFF5A, 32'd0,        1'b0, "store_byte");
        issue_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0,        32'hDEAD5AEF, 1'b0, "load_after_byte");
    endtask

    task automatic test_extension();
        issue_req(1'b0, 2'b00, 1'b1, 32'h43, 32'd0, 32'hFFFFFFDE, 1'b0, "lb_sign");
        issue_req(1'b0, 2'b00, 1'b0, 32'h43, 32'd0, 32'h000000DE, 1'b0, "lbu");
        issue_req(1'b0, 2'b01, 1'b1, 32'h42, 32'd0, 32'hFFFFDEAD, 1'b0, "lh_sign");
        issue_req(1'b0, 2'b01, 1'b0, 32'h40, 32'd0, 32'h00005AEF, 1'b0, "lhu_low");
        issue_req(1'b0, 2'b00, 1'b1, 32'h41, 32'd0, 32'h0000005A, 1'b0, "lb_pos");
        issue_req(1'b0, 2'b00, 1'b1, 32'h40, 32'd0, 32'hFFFFFFEF, 1'b0, "lb_neg");
        issue_req(1'b0, 2'b11, 1'b1, 32'h40, 32'd0, 32'hDEAD5AEF, 1'b0, "size3_word");
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_CHECK_EN
        issue_req(1'b1, 2'b10, 1'b0, 32'h42, 32'h11111111, 32'd0,        1'b1, "mis_store_word");
        issue_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0,        32'hDEAD5AEF, 1'b0, "mis_no_write");
        issue_req(1'b0, 2'b01, 1'b1, 32'h41, 32'd0,        32'd0,        1'b1, "mis_load_half");
        issue_req(1'b0, 2'b00, 1'b0, 32'h43, 32'd0,        32'h000000DE, 1'b0, "byte_never_mis");
`else
        issue_req(1'b1, 2'b10, 1'b0, 32'h42, 32'h11111111, 32'd0,        1'b0, "forced_store_word");
        issue_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0,        32'h11111111, 1'b0, "forced_word_written");
        issue_req(1'b0, 2'b01, 1'b0, 32'h43, 32'd0,        32'h00001111, 1'b0, "forced_load_half");
        issue_req(1'b1, 2'b01, 1'b0, 32'h41, 32'h0000BEEF, 32'd0,        1'b0, "forced_store_half");
        issue_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0,        32'h1111BEEF, 1'b0, "forced_half_lane");
`endif
    endtask

    task automatic test_wrap();
        issue_req(1'b1, 2'b10, 1'b0, 32'h40,   32'hCAFEF00D, 32'd0,        1'b0, "wrap_store");
        issue_req(1'b0, 2'b10, 1'b0, 32'h1040, 32'd0,        32'hCAFEF00D, 1'b0, "wrap_load");
        issue_req(1'b1, 2'b10, 1'b0, 32'h2084, 32'h0BADC0DE, 32'd0,        1'b0, "wrap_store_hi");
        issue_req(1'b0, 2'b10, 1'b0, 32'h84,   32'd0,        32'h0BADC0DE, 1'b0, "wrap_load_lo");
    endtask

    // req_valid held through RESP and req_addr changed during WAIT.
    task automatic test_back_to_back();
        int k;
        int r1;
        int r2;
        exp_rd_q.push_back(32'hCAFEF00D); exp_err_q.push_back(1'b0);
        exp_rd_q.push_back(32'h0BADC0DE); exp_err_q.push_back(1'b0);
        @(posedge clk);
        #1;
        req_wen   = 1'b0;
        req_size  = 2'b10;
        req_sign  = 1'b0;
        req_addr  = 32'h40;
        req_wdata = 32'd0;
        req_valid = 1'b1;
        k = 0;
        r1 = -1;
        r2 = -1;
        while (r2 < 0 && k < 30) begin
            @(negedge clk);
            if (k == 1) req_addr = 32'h84;
            if (k == LAT + 1) begin
                checks++;
                if (stall !== 1'b0) begin failures++; $display("FAIL b2b_resp_stall got=%b exp=0", stall); end
            end
            if (k == LAT + 2) begin
                checks++;
                if (stall !== 1'b1) begin failures++; $display("FAIL b2b_second_stall got=%b exp=1", stall); end
            end
            if (resp_valid) begin
                if (r1 < 0) r1 = k;
                else begin
                    r2 = k;
                    req_valid = 1'b0;
                end
            end
            k++;
        end
        req_valid = 1'b0;
        checks++;
        if (r1 !== LAT + 1) begin failures++; $display("FAIL b2b_first_resp got=%0d exp=%0d", r1, LAT + 1); end
        checks++;
        if (r2 !== 2 * LAT + 3) begin failures++; $display("FAIL b2b_second_resp got=%0d exp=%0d", r2, 2 * LAT + 3); end
    endtask

    task automatic test_reset_mid();
        issue_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, 32'd0,        1'b0, "pre_store_80");
        issue_req(1'b0, 2'b10, 1'b0, 32'h80, 32'd0,        32'h12345678, 1'b0, "pre_load_80");
        @(posedge clk);
        #1;
        req_wen   = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h80;
        req_wdata = 32'hA5A5A5A5;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0)      begin failures++; $display("FAIL midrst_stall got=%b exp=0", stall); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL midrst_resp got=%b exp=0", resp_valid); end
        checks++; if (rdata !== 32'd0)     begin failures++; $display("FAIL midrst_rdata got=%h exp=0", rdata); end
        repeat (3) @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL midrst_late_resp got=%b exp=0", resp_valid); end
        issue_req(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 32'h12345678, 1'b0, "midrst_dropped");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_extension();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_rd_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule
